change_monitor_fifo: RTL and testbench



---
 rtl/change_monitor_fifo.sv | 125 ++++++++++++
 tb/tb_change_monitor_fifo.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/change_monitor_fifo.sv
// Watches a bus every clock, time-stamps each value change (or a baseline on
// enable rising) and queues {time, value, mask} records in a FWFT FIFO.
module change_monitor_fifo #(
    parameter int WIDTH     = 16,
    parameter int TS_WIDTH  = 32,
    parameter int DEPTH     = 8,
    parameter int CNT_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic [WIDTH-1:0]           watch_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_value,
    output logic [WIDTH-1:0]           out_mask,
    output logic [TS_WIDTH-1:0]        out_time,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow,
    output logic [CNT_WIDTH-1:0]       drop_cnt,
    input  logic                       clr_overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    // Consumer handshake: the head record transfers on a rising edge where
    // out_valid && out_ready; out_* stay stable while out_valid && !out_ready.

    logic [TS_WIDTH-1:0] ts;
    logic [WIDTH-1:0]    prev;
    logic                armed;

    logic [WIDTH-1:0]    val_mem  [DEPTH];
    logic [WIDTH-1:0]    mask_mem [DEPTH];
    logic [TS_WIDTH-1:0] time_mem [DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [AW:0]         level_q;

    logic                baseline;
    logic                change;
    logic                push_req;
    logic                pop;
    logic                push_ok;
    logic                drop;
    logic [WIDTH-1:0]    rec_mask;

    always_comb begin
        baseline = enable && !armed;
        // Case inequality so X/Z transitions are recorded in simulation.
        change   = enable && armed && (watch_in !== prev);
        push_req = baseline || change;
        rec_mask = baseline ? '1 : (watch_in ^ prev);
        pop      = (level_q != '0) && out_ready;
        push_ok  = push_req && ((level_q != FULL_LEVEL) || pop);
        drop     = push_req && !push_ok;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts    <= '0;
            prev  <= '0;
            armed <= 1'b0;
        end else begin
            ts    <= ts + TS_WIDTH'(1);
            prev  <= watch_in;
            armed <= enable;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                val_mem[i]  <= '0;
                mask_mem[i] <= '0;
                time_mem[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                val_mem[wr_ptr]  <= watch_in;
                mask_mem[wr_ptr] <= rec_mask;
                time_mem[wr_ptr] <= ts;
                wr_ptr           <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop})
                2'b10:   level_q <= level_q + (AW + 1)'(1);
                2'b01:   level_q <= level_q - (AW + 1)'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // A drop on the same edge as a clear wins, restarting the count at one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (clr_overflow) begin
                drop_cnt <= CNT_WIDTH'(1);
            end else if (drop_cnt != CNT_MAX) begin
                drop_cnt <= drop_cnt + CNT_WIDTH'(1);
            end
        end else if (clr_overflow) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end
    end

    assign out_valid = (level_q != '0);
    assign out_value = val_mem[rd_ptr];
    assign out_mask  = mask_mem[rd_ptr];
    assign out_time  = time_mem[rd_ptr];
    assign level     = level_q;

endmodule

// File: tb/tb_change_monitor_fifo.sv
// Bench for change_monitor_fifo: directed vector table, corner-case sequences
// and randomized traffic checked against a queue-based reference model.
module tb_change_monitor_fifo;

    localparam int WIDTH = 16;
    localparam int TS_WIDTH = 32;
    localparam int DEPTH = 8;
    localparam int CNT_WIDTH = 8;
    localparam int W = TS_WIDTH + 2 * WIDTH;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 enable = 1'b0;
    logic [WIDTH-1:0]     watch_in = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic [WIDTH-1:0]     out_value;
    logic [WIDTH-1:0]     out_mask;
    logic [TS_WIDTH-1:0]  out_time;
    logic [3:0]           level;
    logic                 overflow;
    logic [CNT_WIDTH-1:0] drop_cnt;
    logic                 clr_overflow = 1'b0;

    int tests = 0;
    int fails = 0;

    change_monitor_fifo #(
        .WIDTH(WIDTH), .TS_WIDTH(TS_WIDTH), .DEPTH(DEPTH), .CNT_WIDTH(CNT_WIDTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .watch_in(watch_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_value(out_value),
        .out_mask(out_mask), .out_time(out_time), .level(level),
        .overflow(overflow), .drop_cnt(drop_cnt), .clr_overflow(clr_overflow)
    );

    always #5 clk = ~clk;

    // Reference model: records are {time, value, mask}
    logic [W-1:0]          exp_q[$];
    logic [TS_WIDTH-1:0]   m_ts;
    logic [WIDTH-1:0]      m_prev;
    logic                  m_armed;
    logic                  m_ovf;
    logic [CNT_WIDTH-1:0]  m_cnt;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_ts = '0;
        m_prev = '0;
        m_armed = 1'b0;
        m_ovf = 1'b0;
        m_cnt = '0;
    endtask

    task automatic model_edge();
        logic [W-1:0] rec;
        logic push;
        logic drop;
        drop = 1'b0;
        push = enable && (!m_armed || (watch_in !== m_prev));
        rec = {m_ts, watch_in, (m_armed ? (watch_in ^ m_prev) : {WIDTH{1'b1}})};
        if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
        if (push) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(rec);
            else drop = 1'b1;
        end
        if (drop) begin
            m_ovf = 1'b1;
            if (clr_overflow) m_cnt = 1;
            else if (m_cnt != 8'hFF) m_cnt = m_cnt + 1'b1;
        end else if (clr_overflow) begin
            m_ovf = 1'b0;
            m_cnt = '0;
        end
        m_prev = watch_in;
        m_armed = enable;
        m_ts = m_ts + 1;
    endtask

    task automatic compare_model();
        check("valid", 64'(out_valid), 64'(exp_q.size() != 0));
        check("level", 64'(level), 64'(exp_q.size()));
        check("overflow", 64'(overflow), 64'(m_ovf));
        check("drop_cnt", 64'(drop_cnt), 64'(m_cnt));
        if (exp_q.size() != 0) begin
            check("head_time", 64'(out_time), 64'(exp_q[0][W-1 -: TS_WIDTH]));
            check("head_value", 64'(out_value), 64'(exp_q[0][2*WIDTH-1 -: WIDTH]));
            check("head_mask", 64'(out_mask), 64'(exp_q[0][WIDTH-1:0]));
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_model();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        enable = 1'b0;
        watch_in = '0;
        out_ready = 1'b0;
        clr_overflow = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        int              n;
        logic            en;
        logic [15:0]     w;
        logic            rdy;
        logic            clr;
        logic            ev;
        logic [3:0]      el;
        logic [15:0]     eval;
        logic [15:0]     emask;
        logic [31:0]     etime;
        logic            chk;
    } vec_t;

    vec_t vecs[10];

    initial begin
        logic [31:0] t0;
        logic [15:0] ev;

        vecs[0] = '{3, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0000, 16'h0000, 32'd0,  1'b1};
        vecs[1] = '{1, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 4'd1, 16'h0000, 16'hFFFF, 32'd3,  1'b1};
        vecs[2] = '{1, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0000, 16'h0000, 32'd0,  1'b0};
        vecs[3] = '{5, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0000, 16'h0000, 32'd0,  1'b0};
        vecs[4] = '{1, 1'b1, 16'h0020, 1'b1, 1'b0, 1'b1, 4'd1, 16'h0020, 16'h0020, 32'd10, 1'b1};
        vecs[5] = '{9, 1'b1, 16'h0020, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0000, 16'h0000, 32'd0,  1'b0};
        vecs[6] = '{1, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 4'd1, 16'h0000, 16'h0020, 32'd20, 1'b1};
        vecs[7] = '{9, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0000, 16'h0000, 32'd0,  1'b0};
        vecs[8] = '{1, 1'b1, 16'h0020, 1'b1, 1'b0, 1'b1, 4'd1, 16'h0020, 16'h0020, 32'd30, 1'b1};
        vecs[9] = '{1, 1'b1, 16'h0020, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0000, 16'h0000, 32'd0,  1'b0};

        do_reset();
        check("reset_valid", 64'(out_valid), 64'd0);
        check("reset_value", 64'(out_value), 64'd0);
        check("reset_time", 64'(out_time), 64'd0);

        // Directed table: baseline at time 3, then bit-5 toggles at 10/20/30
        for (int v = 0; v < 10; v++) begin
            enable = vecs[v].en;
            watch_in = vecs[v].w;
            out_ready = vecs[v].rdy;
            clr_overflow = vecs[v].clr;
            repeat (vecs[v].n) step();
            check($sformatf("vec%0d_valid", v), 64'(out_valid), 64'(vecs[v].ev));
            check($sformatf("vec%0d_level", v), 64'(level), 64'(vecs[v].el));
            if (vecs[v].chk) begin
                check($sformatf("vec%0d_value", v), 64'(out_value), 64'(vecs[v].eval));
                check($sformatf("vec%0d_mask", v), 64'(out_mask), 64'(vecs[v].emask));
                check($sformatf("vec%0d_time", v), 64'(out_time), 64'(vecs[v].etime));
            end
        end

        // Overflow: 10 changes into an 8-deep FIFO with no consumer
        out_ready = 1'b0;
        t0 = m_ts;
        for (int i = 0; i < 10; i++) begin
            watch_in = 16'h0100 + 16'(i);
            step();
        end
        check("ovf_level", 64'(level), 64'd8);
        check("ovf_flag", 64'(overflow), 64'd1);
        check("ovf_cnt", 64'(drop_cnt), 64'd2);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("drain_valid", 64'(out_valid), 64'd1);
            check("drain_time", 64'(out_time), 64'(t0 + 32'(i)));
            check("drain_value", 64'(out_value), 64'(16'h0100 + 16'(i)));
            step();
        end
        check("drain_empty", 64'(level), 64'd0);

        // Full FIFO with a change and a pop on the same edge
        clr_overflow = 1'b1;
        step();
        clr_overflow = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            watch_in = 16'h0200 + 16'(i);
            step();
        end
        check("full_level", 64'(level), 64'd8);
        watch_in = 16'h02FF;
        out_ready = 1'b1;
        step();
        check("pushpop_level", 64'(level), 64'd8);
        check("pushpop_ovf", 64'(overflow), 64'd0);
        check("pushpop_cnt", 64'(drop_cnt), 64'd0);
        for (int i = 0; i < 8; i++) begin
            ev = (i == 7) ? 16'h02FF : (16'h0201 + 16'(i));
            check("pushpop_order", 64'(out_value), 64'(ev));
            step();
        end

        // clr_overflow alone, then coinciding with a drop
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            watch_in = 16'h0300 + 16'(i);
            step();
        end
        check("clr_pre_cnt", 64'(drop_cnt), 64'd2);
        clr_overflow = 1'b1;
        step();
        check("clr_ovf", 64'(overflow), 64'd0);
        check("clr_cnt", 64'(drop_cnt), 64'd0);
        watch_in = 16'h03AA;
        step();
        clr_overflow = 1'b0;
        check("clrdrop_ovf", 64'(overflow), 64'd1);
        check("clrdrop_cnt", 64'(drop_cnt), 64'd1);

        // Saturation of the drop counter
        for (int i = 0; i < 260; i++) begin
            watch_in = 16'h0400 + 16'(i);
            step();
        end
        check("sat_cnt", 64'(drop_cnt), 64'd255);

        // Asynchronous reset mid-drain at level 5
        out_ready = 1'b1;
        repeat (3) step();
        check("mid_level", 64'(level), 64'd5);
        out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_valid", 64'(out_valid), 64'd0);
        check("async_level", 64'(level), 64'd0);
        check("async_ovf", 64'(overflow), 64'd0);
        check("async_cnt", 64'(drop_cnt), 64'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        enable = 1'b0;
        repeat (4) step();
        enable = 1'b1;
        step();
        check("rebase_valid", 64'(out_valid), 64'd1);
        check("rebase_time", 64'(out_time), 64'd4);
        check("rebase_mask", 64'(out_mask), 64'hFFFF);
        check("rebase_value", 64'(out_value), 64'(watch_in));

        // Randomized traffic with varying consumer pressure
        for (int p = 0; p < 4; p++) begin
            for (int c = 0; c < 150; c++) begin
                enable = ($urandom_range(0, 15) != 0);
                if ($urandom_range(0, 1) == 1) begin
                    if ($urandom_range(0, 3) == 0) watch_in = 16'($urandom);
                    else watch_in = watch_in ^ (16'h1 << $urandom_range(0, 15));
                end
                out_ready = ($urandom_range(0, 3) < p + 1);
                clr_overflow = ($urandom_range(0, 31) == 0);
                step();
            end
        end
        clr_overflow = 1'b0;
        enable = 1'b0;
        out_ready = 1'b1;
        repeat (DEPTH + 2) step();
        check("final_empty", 64'(level), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
